mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu.sv | 115 +++++++++++
 tb/tb_mdu.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared opcode, state and result types for the HI/LO multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {S_IDLE, S_RUN} md_state_e;

  // wr=0 marks a divide-by-zero: HI/LO are left alone at completion.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } md_res_t;

  function automatic logic is_start(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle mult/div unit owning HI/LO; a down-counter models fixed latencies
// while the result is computed up front and held until the busy period ends.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        occupied,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  md_res_t     r_pend, w_res;
  logic [31:0] r_hi, r_lo;
  logic        w_start, w_commit;
  md_op_e      w_op;

  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_a_abs, w_b_abs, w_b_nz, w_qm, w_rm, w_qu, w_ru;
  logic        w_div_zero;

  assign w_op = md_op_e'(MDOp);

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of hitting the language's signed-overflow corner.
  always_comb begin
    w_prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    w_prod_u   = {32'd0, A} * {32'd0, B};
    w_div_zero = (B == 32'd0);
    w_b_nz     = w_div_zero ? 32'd1 : B;
    w_a_abs    = A[31] ? -A : A;
    w_b_abs    = w_div_zero ? 32'd1 : (B[31] ? -B : B);
    w_qu       = A / w_b_nz;
    w_ru       = A % w_b_nz;
    w_qm       = w_a_abs / w_b_abs;
    w_rm       = w_a_abs % w_b_abs;
    w_res      = '0;
    case (w_op)
      MD_MULT:  w_res = '{hi: w_prod_s[63:32], lo: w_prod_s[31:0], wr: 1'b1};
      MD_MULTU: w_res = '{hi: w_prod_u[63:32], lo: w_prod_u[31:0], wr: 1'b1};
      MD_DIV:   w_res = '{hi: A[31] ? -w_rm : w_rm,
                          lo: (A[31] ^ B[31]) ? -w_qm : w_qm,
                          wr: !w_div_zero};
      MD_DIVU:  w_res = '{hi: w_ru, lo: w_qu, wr: !w_div_zero};
      default:  w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (is_start(MDOp)) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
          w_cnt_nxt   = (w_op == MD_MULT || w_op == MD_MULTU) ? CW'(MULT_CYCLES)
                                                              : CW'(DIV_CYCLES);
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start) r_pend <= w_res;
      // Ops arriving during RUN are dropped; only the idle state honours mthi/mtlo.
      if (w_commit) begin
        if (r_pend.wr) begin
          r_hi <= r_pend.hi;
          r_lo <= r_pend.lo;
        end
      end else if (r_state == S_IDLE) begin
        if (w_op == MD_MTHI) r_hi <= A;
        if (w_op == MD_MTLO) r_lo <= A;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign occupied = busy | is_start(MDOp);
  assign HI       = r_hi;
  assign LO       = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: starts push expected HI/LO and busy length; a monitor
// pops and compares on each falling edge of busy.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        busy, occupied;
  logic [31:0] HI, LO;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .A(A), .B(B),
    .busy(busy), .occupied(occupied), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_busy = 1'b0;
  int   run_len = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      run_len   = 0;
    end else begin
      if (busy) run_len++;
      else if (prev_busy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL completion: got unexpected busy fall expected none");
        end else begin
          m_e = q.pop_front();
          chk({m_e.name, " HI"}, HI, m_e.hi);
          chk({m_e.name, " LO"}, LO, m_e.lo);
          chk({m_e.name, " busy_len"}, 32'(run_len), 32'(m_e.len));
        end
        run_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int len,
                       input string nm);
    MDOp = op; A = a; B = b;
    #1;
    chk({nm, " occupied"}, 32'(occupied), 32'd1);
    q.push_back('{ehi, elo, len, nm});
    @(posedge clk); #1;
    MDOp = 3'd0;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    MDOp = op; A = a;
    @(posedge clk); #1;
    MDOp = 3'd0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: got busy stuck expected idle within 40 cycles");
  endtask

  initial begin
    reset = 1'b1; MDOp = 3'd0; A = '0; B = '0;
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst occupied", 32'(occupied), 32'd0);
    chk("rst HI", HI, 32'd0);
    chk("rst LO", LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    start(3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, "mult");
    wait_idle();
    start(3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, "multu");
    wait_idle();
    start(3'd1, 32'h0001_2345, 32'h0001_0000, 32'h0000_0001, 32'h2345_0000, 5, "mult_b2b");
    wait_idle();
    start(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg");
    wait_idle();
    start(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, "div_ovf");
    wait_idle();
    start(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, "divu");
    wait_idle();

    mt(3'd5, 32'h1234);
    chk("mthi HI", HI, 32'h1234);
    mt(3'd6, 32'h5678);
    chk("mtlo LO", LO, 32'h5678);
    chk("mtlo HI kept", HI, 32'h1234);

    start(3'd4, 32'd5, 32'd0, 32'h1234, 32'h5678, 10, "divu_zero");
    wait_idle();
    start(3'd3, 32'd5, 32'd0, 32'h1234, 32'h5678, 10, "div_zero");
    wait_idle();

    start(3'd3, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 10, "div_ign");
    @(posedge clk); #1;
    MDOp = 3'd5; A = 32'hDEAD;
    #1;
    chk("ign occupied", 32'(occupied), 32'd1);
    @(posedge clk); #1;
    MDOp = 3'd0;
    chk("ign HI held", HI, 32'h1234);
    wait_idle();

    start(3'd3, 32'd9, 32'd2, 32'd1, 32'd4, 10, "div_rst");
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst HI", HI, 32'd0);
    chk("midrst LO", LO, 32'd0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;

    start(3'd1, 32'd7, 32'd6, 32'd0, 32'd42, 5, "mult_post_rst");
    wait_idle();
    repeat (2) begin @(posedge clk); #1; end
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
